// File: rtl/regime_encoder.sv
// Sequential posit regime encoder: run of identical bits, terminator, then MSB-aligned tail.
// Build option: define SEED_SATURATE_EN to expose the sat (seed clamped) output.
module regime_encoder #(
  parameter int BITS = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [BITS-1:0] seed,
  input  logic        [BITS-1:0] tail,
  input  logic                   sign,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic        [BITS-1:0] posit
`ifdef SEED_SATURATE_EN
  ,
  output logic                   sat
`endif
);

  localparam int CW = $clog2(BITS) + 1;
  localparam logic signed [BITS-1:0] K_MAX = BITS'(BITS - 2);
  localparam logic signed [BITS-1:0] K_MIN = BITS'(2 - BITS);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    TERM,
    FILL,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic        [CW-1:0]   cnt;
  logic signed [CW-1:0]   pos;
  logic        [CW-2:0]   pos_idx;
  logic        [BITS-2:0] work;
  logic        [BITS-1:0] tail_q;
  logic                   sign_q;
  logic                   run_bit;

  logic        [CW-1:0]   r_init;
  logic                   run_bit_init;
  logic                   clamp;
  logic        [CW-1:0]   shamt;
  logic        [BITS-1:0] tail_sh;
  logic        [BITS-2:0] fill_bits;

  // Clamped seeds keep their sign, so the run bit still follows seed's MSB.
  always_comb begin
    clamp        = 1'b0;
    run_bit_init = ~seed[BITS-1];
    r_init       = '0;
    if (seed > K_MAX) begin
      clamp  = 1'b1;
      r_init = CW'(BITS - 1);
    end else if (seed < K_MIN) begin
      clamp  = 1'b1;
      r_init = CW'(BITS - 2);
    end else if (seed[BITS-1]) begin
      r_init = CW'(-seed);
    end else begin
      r_init = CW'(seed + 1'b1);
    end
  end

  assign pos_idx = pos[CW-2:0];

  // Tail MSB lands at bit pos-1; shift amount is BITS-pos, only used when pos>0.
  always_comb begin
    shamt     = CW'(BITS) - $unsigned(pos);
    tail_sh   = tail_q >> shamt;
    fill_bits = '0;
    if (pos > 0) begin
      fill_bits = tail_sh[BITS-2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          state_nxt = TERM;
        end
      end
      TERM:    state_nxt = FILL;
      FILL:    state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pos     <= '0;
      work    <= '0;
      tail_q  <= '0;
      sign_q  <= 1'b0;
      run_bit <= 1'b0;
      posit   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            tail_q  <= tail;
            sign_q  <= sign;
            run_bit <= run_bit_init;
            cnt     <= r_init;
            pos     <= CW'(BITS - 2);
            work    <= '0;
          end
        end
        RUN: begin
          work[pos_idx] <= run_bit;
          pos           <= pos - 1'b1;
          cnt           <= cnt - 1'b1;
        end
        TERM: begin
          if (!pos[CW-1]) begin
            work[pos_idx] <= ~run_bit;
          end
        end
        FILL: begin
          posit <= {sign_q, work | fill_bits};
        end
        default: ;
      endcase
    end
  end

`ifdef SEED_SATURATE_EN
  logic sat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sat_q <= clamp;
    end
  end

  assign sat = sat_q & (state == DONE);
`endif

endmodule

// File: tb/tb_regime_encoder.sv
// Directed bench for regime_encoder (BITS=32): encodings, clamping, latency, backpressure, reset.
module tb_regime_encoder;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] seed;
  logic        [31:0] tail;
  logic               sign;
  logic               out_valid;
  logic               out_ready;
  logic        [31:0] posit;
  logic               sat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regime_encoder #(.BITS(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .seed     (seed),
    .tail     (tail),
    .sign     (sign),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .posit    (posit)
`ifdef SEED_SATURATE_EN
    ,
    .sat      (sat)
`endif
  );

`ifndef SEED_SATURATE_EN
  assign sat = 1'b0;
`endif

  // Drives one request from IDLE, waits (bounded) for out_valid, then completes the handshake.
  task automatic run_req(input int s, input logic [31:0] t, input logic sg,
                         output logic [31:0] p, output int lat, output logic st);
    int n;
    seed     = s;
    tail     = t;
    sign     = sg;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = n + 1;
    p   = posit;
    st  = sat;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || posit !== 32'h0 || sat !== 1'b0) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b posit=%h sat=%b, want 1 0 00000000 0",
               in_ready, out_valid, posit, sat);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] p;
    int          lat;
    logic        st;
    run_req(0, 32'hFFFF_FFFF, 1'b0, p, lat, st);
    checks++;
    if (p !== 32'h5FFF_FFFF || lat !== 4) begin
      failures++;
      $display("FAIL k0: posit=%h lat=%0d, want 5fffffff 4", p, lat);
    end
    run_req(-1, 32'h0, 1'b0, p, lat, st);
    checks++;
    if (p !== 32'h2000_0000 || lat !== 4) begin
      failures++;
      $display("FAIL kneg1: posit=%h lat=%0d, want 20000000 4", p, lat);
    end
    run_req(2, 32'hA000_0000, 1'b1, p, lat, st);
    checks++;
    if (p !== 32'hF500_0000 || lat !== 6) begin
      failures++;
      $display("FAIL k2: posit=%h lat=%0d, want f5000000 6", p, lat);
    end
`ifdef SEED_SATURATE_EN
    checks++;
    if (st !== 1'b0) begin
      failures++;
      $display("FAIL k2_sat: sat=%b, want 0", st);
    end
`endif
  endtask

  task automatic test_clamp();
    logic [31:0] p;
    int          lat;
    logic        st;
    run_req(40, 32'hFFFF_FFFF, 1'b0, p, lat, st);
    checks++;
    if (p !== 32'h7FFF_FFFF || lat !== 34) begin
      failures++;
      $display("FAIL clamp_hi: posit=%h lat=%0d, want 7fffffff 34", p, lat);
    end
`ifdef SEED_SATURATE_EN
    checks++;
    if (st !== 1'b1) begin
      failures++;
      $display("FAIL clamp_hi_sat: sat=%b, want 1", st);
    end
`endif
    run_req(-100, 32'hFFFF_FFFF, 1'b0, p, lat, st);
    checks++;
    if (p !== 32'h0000_0001 || lat !== 33) begin
      failures++;
      $display("FAIL clamp_lo: posit=%h lat=%0d, want 00000001 33", p, lat);
    end
`ifdef SEED_SATURATE_EN
    checks++;
    if (st !== 1'b1) begin
      failures++;
      $display("FAIL clamp_lo_sat: sat=%b, want 1", st);
    end
`endif
    run_req(30, 32'h0, 1'b1, p, lat, st);
    checks++;
    if (p !== 32'hFFFF_FFFF || lat !== 34) begin
      failures++;
      $display("FAIL edge_k30: posit=%h lat=%0d, want ffffffff 34", p, lat);
    end
    run_req(-30, 32'hFFFF_FFFF, 1'b0, p, lat, st);
    checks++;
    if (p !== 32'h0000_0001 || lat !== 33) begin
      failures++;
      $display("FAIL edge_kneg30: posit=%h lat=%0d, want 00000001 33", p, lat);
    end
`ifdef SEED_SATURATE_EN
    checks++;
    if (st !== 1'b0) begin
      failures++;
      $display("FAIL edge_kneg30_sat: sat=%b, want 0", st);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int n;
    seed     = 0;
    tail     = 32'hFFFF_FFFF;
    sign     = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    seed = -1;
    tail = 32'h0;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    // in_valid stays high throughout DONE with a different request pending
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || posit !== 32'h5FFF_FFFF || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold%0d: out_valid=%b posit=%h in_ready=%b, want 1 5fffffff 0",
                 c, out_valid, posit, in_ready);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL after_hs: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL next_accept: in_ready=%b, want 0", in_ready);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (posit !== 32'h2000_0000 || n + 1 !== 4) begin
      failures++;
      $display("FAIL second_word: posit=%h lat=%0d, want 20000000 4", posit, n + 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] p;
    int          lat;
    logic        st;
    int          seen;
    seed     = 10;
    tail     = 32'h1234_5678;
    sign     = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || posit !== 32'h0) begin
      failures++;
      $display("FAIL mid_run_reset: in_ready=%b out_valid=%b posit=%h, want 1 0 00000000",
               in_ready, out_valid, posit);
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL stray_valid: out_valid high %0d cycles, want 0", seen);
    end
    run_req(0, 32'hFFFF_FFFF, 1'b0, p, lat, st);
    checks++;
    if (p !== 32'h5FFF_FFFF || lat !== 4) begin
      failures++;
      $display("FAIL post_reset: posit=%h lat=%0d, want 5fffffff 4", p, lat);
    end
  endtask

  task automatic test_reset_mid_done();
    int n;
    seed     = 3;
    tail     = 32'hFFFF_FFFF;
    sign     = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || posit !== 32'h0) begin
      failures++;
      $display("FAIL mid_done_reset: in_ready=%b out_valid=%b posit=%h, want 1 0 00000000",
               in_ready, out_valid, posit);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] p;
    logic [31:0] t;
    logic [31:0] mask;
    logic [31:0] exp_data;
    logic        sg;
    logic        st;
    logic        b;
    int          lat;
    int          k;
    int          m;
    int          nb;
    int          k_dec;
    int          r;
    for (int i = 0; i < 40; i++) begin
      k  = int'($urandom_range(60)) - 30;
      t  = $urandom;
      sg = 1'($urandom_range(1));
      run_req(k, t, sg, p, lat, st);
      b = p[30];
      m = 0;
      for (int j = 30; j >= 0; j--) begin
        if (p[j] != b) break;
        m++;
      end
      k_dec = b ? m - 1 : -m;
      nb    = 30 - m;
      r     = (k >= 0) ? k + 1 : -k;
      mask  = '0;
      exp_data = '0;
      if (nb > 0) begin
        mask     = (32'd1 << nb) - 32'd1;
        exp_data = t >> (32 - nb);
      end
      checks++;
      if (k_dec !== k || (p & mask) !== exp_data || p[31] !== sg || lat !== r + 3) begin
        failures++;
        $display("FAIL sweep k=%0d: posit=%h decoded=%0d data=%h lat=%0d, want k=%0d data=%h sign=%b lat=%0d",
                 k, p, k_dec, p & mask, lat, k, exp_data, sg, r + 3);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    seed      = '0;
    tail      = '0;
    sign      = 1'b0;
    test_reset();
    test_basic();
    test_clamp();
    test_back_to_back();
    test_reset_mid_run();
    test_reset_mid_done();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
